shift_capture_ctrl: RTL and testbench
=====================================

Name: shift_capture_ctrl

Overview:
- Controller that sequences a WIDTH-bit serial-in/parallel-out shift register.
- Arms on a start pulse and shifts exactly WIDTH serial bits, MSB first.
- Presents the captured word with a valid/ready handshake and flags start requests that arrive while it is busy.
- Sits between a serial input pin/stream and the parallel consumer logic.

Parameters:
- WIDTH, 5: number of bits captured per frame (>= 2).
- CNT_W, 3: bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to capture one frame; sampled only in IDLE.
- si  input  1  serial data bit.
- out_ready  input  1  consumer accepts the word when high while out_valid is high.
- clr_ovr  input  1  synchronous clear of the overrun flag.
- data_out  output  WIDTH  captured word; first received bit lands in data_out[WIDTH-1].
- out_valid  output  1  data_out holds a complete frame.
- busy  output  1  high in SHIFT or HOLD.
- bit_cnt  output  CNT_W  bits shifted so far in the current frame.
- overrun  output  1  sticky flag; a start was dropped because the block was busy.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - Shift register, data_out, bit_cnt = 0.
  - out_valid, busy, overrun = 0.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 at edge E0 -> SHIFT; bit_cnt=0; shift register cleared.
  - start=0 -> stay in IDLE.
- SHIFT:
  - Every edge: sr <= {sr[WIDTH-2:0], si}; bit_cnt <= bit_cnt+1.
  - si is sampled at edges E1..E_WIDTH, i.e. the first data bit is presented in the cycle after start is taken.
  - On the edge where bit_cnt goes WIDTH-1 -> WIDTH, the final shifted value is loaded into data_out; state -> HOLD; out_valid=1.
  - Latency: out_valid rises WIDTH edges after the start edge.
- HOLD:
  - data_out and out_valid are held stable; bit_cnt stays at WIDTH.
  - out_ready=1 -> transfer. Next state IDLE; out_valid=0; bit_cnt=0. data_out keeps its last value.
  - Exception: if start=1 on the same edge as the transfer, go directly to SHIFT (back-to-back frames with no idle cycle). This start is not an overrun.
- busy = (state != IDLE), registered with the state.
- Overrun:
  - start=1 while in SHIFT, or in HOLD without out_ready, sets overrun=1. The frame in progress is unaffected and the request is dropped.
  - clr_ovr=1 clears overrun on the next edge.
  - If a set condition and clr_ovr occur together, set wins (overrun=1).
- out_ready while out_valid=0 is ignored.
- si is don't-care outside SHIFT.
- Reset mid-frame aborts immediately with all outputs at reset values. No partial word is presented.
- bit_cnt never exceeds WIDTH and never wraps.

Test Plan:
- Reset then single frame (WIDTH=5): start pulse at E0, si=1,0,1,1,0 at E1..E5, out_ready=1 -> out_valid high after E5 with data_out=5'b10110; busy=1 from E0 to E5; returns to IDLE after E6.
- Backpressure: capture si=1,1,1,0,1 with out_ready=0 for 4 cycles -> data_out=5'b11101 and out_valid stay stable in HOLD; raise out_ready -> out_valid=0 next edge.
- Back-to-back: in HOLD assert out_ready=1 and start=1 together, then feed 0,0,1,0,1 -> no IDLE cycle, second word 5'b00101 valid 5 edges later; overrun remains 0.
- Overrun: pulse start at E2 mid-frame -> overrun=1 next edge and frame data unchanged; assert clr_ovr and a busy start on the same edge -> overrun stays 1; clr_ovr alone -> overrun=0.
- Reset mid-operation: assert rst after 3 bits shifted -> bit_cnt=0, busy=0, out_valid=0, data_out=0 immediately (asynchronous); a fresh frame then captures correctly.
- Idle robustness: toggle si and out_ready with start=0 for 10 cycles -> all outputs remain at reset values.

Source files
------------

// File: rtl/shift_capture_ctrl.sv
// shift_capture_ctrl: captures WIDTH serial bits (MSB first) into a parallel
// word after a start pulse, then offers the word on a valid/ready handshake.
// A start that arrives while a frame is in flight or waiting is dropped and
// recorded in a sticky overrun flag.
module shift_capture_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             si,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             ovr_set;
    logic [WIDTH-1:0] sr_shifted;

    assign sr_shifted = {sr_q[WIDTH-2:0], si};

    // Next-state logic: sequence IDLE -> SHIFT -> HOLD and track overrun.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d = state_q;
        sr_d    = sr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                ovr_set = start;
                sr_d    = sr_shifted;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    data_d  = sr_shifted;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Transfer; a simultaneous start chains straight into the
                    // next frame without an idle cycle and is not an overrun.
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    if (start) begin
                        state_d = SHIFT;
                        sr_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ovr_set = start;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set beats clear when both happen on the same edge.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would create order-dependent
        // simulation and mismatch the synthesised hardware.
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign bit_cnt   = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_shift_capture_ctrl.sv
// Self-checking bench for shift_capture_ctrl: directed scenarios followed by
// randomized traffic, all compared against a frame-level behavioural model.
module tb_shift_capture_ctrl;

    localparam int WIDTH = 5;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic             si;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    int n_checks;
    int n_errors;

    // Behavioural model: a frame is "in flight" until WIDTH bits are collected,
    // then "offered" until accepted. The word is accumulated arithmetically.
    bit m_in_frame;
    bit m_offered;
    int m_bits;
    int m_acc;
    int m_word;
    bit m_ovr;

    shift_capture_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .si        (si),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 0;
        m_offered  = 0;
        m_bits     = 0;
        m_acc      = 0;
        m_word     = 0;
        m_ovr      = 0;
    endfunction

    function automatic void model_step(input bit s, input bit d, input bit r, input bit c);
        bit dropped;
        dropped = 0;
        if (!m_in_frame) begin
            if (s) begin
                m_in_frame = 1;
                m_bits     = 0;
                m_acc      = 0;
            end
        end else if (!m_offered) begin
            dropped = s;
            m_acc   = (m_acc * 2 + int'(d)) % (1 << WIDTH);
            m_bits  = m_bits + 1;
            if (m_bits == WIDTH) begin
                m_word    = m_acc;
                m_offered = 1;
            end
        end else if (r) begin
            m_offered = 0;
            m_bits    = 0;
            m_acc     = 0;
            m_in_frame = s;
        end else begin
            dropped = s;
        end
        if (dropped) m_ovr = 1;
        else if (c) m_ovr = 0;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".data"},    int'(data_out),  m_word);
        check({tag, ".valid"},   int'(out_valid), int'(m_offered));
        check({tag, ".busy"},    int'(busy),      int'(m_in_frame));
        check({tag, ".bit_cnt"}, int'(bit_cnt),   m_bits);
        check({tag, ".overrun"}, int'(overrun),   int'(m_ovr));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare 1ns later.
    task automatic tick(input bit s, input bit d, input bit r, input bit c, input string tag);
        start = s; si = d; out_ready = r; clr_ovr = c;
        @(posedge clk);
        model_step(s, d, r, c);
        #1;
        compare_all(tag);
    endtask

    // Feed one word's bits MSB first with the given out_ready level.
    task automatic feed_word(input logic [WIDTH-1:0] w, input bit r, input string tag);
        for (int i = WIDTH - 1; i >= 0; i--) tick(1'b0, w[i], r, 1'b0, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("reset_async");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        start = 0; si = 0; out_ready = 0; clr_ovr = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single frame 10110 with out_ready already high.
        tick(1, 0, 1, 0, "f1_start");
        check("f1_busy_e0", int'(busy), 1);
        feed_word(5'b10110, 1'b1, "f1_bits");
        check("f1_word", int'(data_out), 5'b10110);
        check("f1_valid", int'(out_valid), 1);
        tick(0, 0, 1, 0, "f1_xfer");
        check("f1_idle_busy", int'(busy), 0);

        // Backpressure: word must stay put while out_ready is low.
        tick(1, 0, 0, 0, "bp_start");
        feed_word(5'b11101, 1'b0, "bp_bits");
        repeat (4) tick(0, 1, 0, 0, "bp_hold");
        check("bp_word", int'(data_out), 5'b11101);
        check("bp_cnt", int'(bit_cnt), WIDTH);
        tick(0, 0, 1, 0, "bp_xfer");
        check("bp_valid_drop", int'(out_valid), 0);

        // Back-to-back frames: accept and restart on the same edge.
        tick(1, 0, 0, 0, "b2b_start");
        feed_word(5'b01101, 1'b0, "b2b_w1");
        tick(1, 0, 1, 0, "b2b_chain");
        check("b2b_busy", int'(busy), 1);
        feed_word(5'b00101, 1'b0, "b2b_w2");
        check("b2b_word2", int'(data_out), 5'b00101);
        check("b2b_ovr", int'(overrun), 0);
        tick(0, 0, 1, 0, "b2b_xfer");

        // Overrun: busy start at E2, then set-beats-clear, then clear alone.
        tick(1, 0, 0, 0, "ov_start");
        tick(0, 1, 0, 0, "ov_b4");
        tick(1, 0, 0, 0, "ov_b3_start");
        check("ov_set", int'(overrun), 1);
        tick(0, 0, 0, 0, "ov_b2");
        tick(0, 1, 0, 0, "ov_b1");
        tick(0, 1, 0, 0, "ov_b0");
        check("ov_word", int'(data_out), 5'b10011);
        tick(1, 0, 0, 1, "ov_set_vs_clr");
        check("ov_set_wins", int'(overrun), 1);
        tick(0, 0, 0, 1, "ov_clr");
        check("ov_cleared", int'(overrun), 0);
        tick(0, 0, 1, 0, "ov_xfer");

        // Asynchronous reset after three bits, then a clean frame.
        tick(1, 0, 0, 0, "mr_start");
        tick(0, 1, 0, 0, "mr_b");
        tick(0, 1, 0, 0, "mr_b");
        tick(0, 1, 0, 0, "mr_b");
        check("mr_cnt3", int'(bit_cnt), 3);
        do_reset();
        check("mr_data0", int'(data_out), 0);
        tick(1, 0, 0, 0, "mr2_start");
        feed_word(5'b01011, 1'b0, "mr2_bits");
        check("mr2_word", int'(data_out), 5'b01011);
        tick(0, 0, 1, 0, "mr2_xfer");
        do_reset();

        // Idle robustness: si and out_ready toggle without start.
        for (int i = 0; i < 10; i++) tick(0, i[0], ~i[0], 0, "idle");
        check("idle_data", int'(data_out), 0);
        check("idle_busy", int'(busy), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick(($urandom_range(0, 3) == 0), 1'($urandom),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
